// File: rtl/inst_mem_sync.sv
// Synchronous-read RV32 instruction memory: byte-address fetch port plus a program-load port, scrubbed to zero after reset.
// Latency: a fetch accepted in cycle N presents registered results in N+1; a load is written at the edge ending its accept cycle.
// Backpressure: both ports are held off during the post-reset scrub; in RUN a fetch is refused whenever a load is offered.
// Optional feature macro: INST_MEM_PARITY_EN (stores an even-parity bit per word; a parity mismatch is reported as fetch_err 2'b11).
module inst_mem_sync #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        init_done,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  output logic [1:0]  fetch_err,
  input  logic        load_valid,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic        load_err
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef INST_MEM_PARITY_EN
  localparam int WORD_W = 33;
`else
  localparam int WORD_W = 32;
`endif

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_MISAL  = 2'b01;
  localparam logic [1:0] ERR_RANGE  = 2'b10;
`ifdef INST_MEM_PARITY_EN
  localparam logic [1:0] ERR_PARITY = 2'b11;
`endif

  typedef enum logic {
    ST_SCRUB = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] scrub_cnt_q, scrub_cnt_d;

  // Storage has no reset: only the scrub sequence clears it.
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;

  logic              run;
  logic              fetch_acc;
  logic              load_acc;
  logic [1:0]        fetch_addr_err;
  logic [1:0]        load_addr_err;
  logic [ADDR_W-1:0] fetch_idx;
  logic [ADDR_W-1:0] load_idx;
  logic [WORD_W-1:0] rd_word;

  logic        fetch_valid_q, fetch_valid_d;
  logic [31:0] fetch_inst_q,  fetch_inst_d;
  logic [1:0]  fetch_err_q,   fetch_err_d;
  logic        load_err_q,    load_err_d;

  // Misalignment wins over range; any upper address bit set is an error, never an alias.
  function automatic logic [1:0] addr_check(input logic [31:0] a);
    logic [1:0] r;
    r = ERR_OK;
    if (a[1:0] != 2'b00) begin
      r = ERR_MISAL;
    end else if (a[31:ADDR_W+2] != '0) begin
      r = ERR_RANGE;
    end
    return r;
  endfunction

  assign run            = (state_q == ST_RUN);
  assign init_done      = run;
  assign load_ready     = run;
  // Single-port array: a load offered this cycle owns it, so fetch is held off.
  assign fetch_ready    = run & ~load_valid;

  assign load_acc       = load_valid & load_ready;
  assign fetch_acc      = fetch_req & fetch_ready;
  assign fetch_addr_err = addr_check(fetch_addr);
  assign load_addr_err  = addr_check(load_addr);
  assign fetch_idx      = fetch_addr[ADDR_W+1:2];
  assign load_idx       = load_addr[ADDR_W+1:2];
  assign rd_word        = mem_q[fetch_idx];

  // State and scrub counter registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_SCRUB;
      scrub_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      scrub_cnt_q <= scrub_cnt_d;
    end
  end

  // Scrub walks every word once, then the block stays in RUN until the next reset.
  always_comb begin
    state_d     = state_q;
    scrub_cnt_d = scrub_cnt_q;
    case (state_q)
      ST_SCRUB: begin
        scrub_cnt_d = scrub_cnt_q + 1'b1;
        if (scrub_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_SCRUB;
      end
    endcase
  end

  // Write-port mux: scrub zeroes (parity included), otherwise a well-addressed load.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = load_idx;
    mem_wdata = '0;
    if (state_q == ST_SCRUB) begin
      mem_we    = 1'b1;
      mem_waddr = scrub_cnt_q;
      mem_wdata = '0;
    end else if (load_acc && (load_addr_err == ERR_OK)) begin
      mem_we    = 1'b1;
      mem_waddr = load_idx;
`ifdef INST_MEM_PARITY_EN
      mem_wdata = {^load_data, load_data};
`else
      mem_wdata = load_data;
`endif
    end
  end

  // Array write; a fetch in the following cycle sees the new word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Fetch result and load-drop next-state; results hold when nothing is accepted.
  always_comb begin
    fetch_valid_d = fetch_acc;
    fetch_inst_d  = fetch_inst_q;
    fetch_err_d   = fetch_err_q;
    load_err_d    = load_acc & (load_addr_err != ERR_OK);
    if (fetch_acc) begin
      fetch_err_d = fetch_addr_err;
`ifdef INST_MEM_PARITY_EN
      if ((fetch_addr_err == ERR_OK) && (^rd_word != 1'b0)) begin
        fetch_err_d = ERR_PARITY;
      end
`endif
      if (fetch_err_d != ERR_OK) begin
        fetch_inst_d = NOP_INST;
      end else begin
        fetch_inst_d = rd_word[31:0];
      end
    end
  end

  // Registered fetch/load outputs; reset clears any pending fetch result.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fetch_valid_q <= 1'b0;
      fetch_inst_q  <= NOP_INST;
      fetch_err_q   <= ERR_OK;
      load_err_q    <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_valid_d;
      fetch_inst_q  <= fetch_inst_d;
      fetch_err_q   <= fetch_err_d;
      load_err_q    <= load_err_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_inst  = fetch_inst_q;
  assign fetch_err   = fetch_err_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Bench for inst_mem_sync (ADDR_W=4): directed fetch/load vectors with a queued scoreboard.
// Expected fetch results are pushed when a fetch is issued; a negedge monitor pops and compares.
// Define INST_MEM_PARITY_EN for both files to exercise the parity error path.
module tb_inst_mem_sync;

  localparam int          ADDR_W = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        init_done;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [1:0]  fetch_err;
  logic        load_valid = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        load_ready;
  logic        load_err;

  int vectors = 0;
  int miscompares = 0;
  logic [33:0] exp_q [$];

  inst_mem_sync #(.ADDR_W(ADDR_W), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .init_done  (init_done),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_inst (fetch_inst),
    .fetch_err  (fetch_err),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented fetch result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (nrst === 1'b1 && fetch_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_fetch_valid", 32'd1, 32'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("fetch_inst", fetch_inst, e[33:2]);
        check("fetch_err", {30'd0, fetch_err}, {30'd0, e[1:0]});
      end
    end
  end

  // Drive one fetch for a cycle and queue its expected result.
  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ee);
    fetch_req  = 1'b1;
    fetch_addr = a;
    #1;
    check("fetch_ready", {31'd0, fetch_ready}, 32'd1);
    exp_q.push_back({ei, ee});
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  // Drive one load for a cycle and check the following-cycle drop pulse.
  task automatic load(input logic [31:0] a, input logic [31:0] d, input logic ee);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    @(posedge clk); #1;
    load_valid = 1'b0;
    check("load_err", {31'd0, load_err}, {31'd0, ee});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Count cycles from reset release until init_done; the bound keeps a stuck DUT from hanging the run.
  task automatic wait_init();
    int cnt;
    cnt = 0;
    check("ready_at_release", {30'd0, init_done, fetch_ready}, 32'd0);
    while (init_done !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 15) check("not_ready_at_15", {29'd0, init_done, fetch_ready, load_ready}, 32'd0);
    end
    check("init_latency", cnt, 32'd16);
    check("ready_after_init", {29'd0, init_done, fetch_ready, load_ready}, 32'd7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset values.
    @(posedge clk); #1;
    check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_fetch_inst", fetch_inst, NOP);
    check("rst_fetch_err", {30'd0, fetch_err}, 32'd0);
    check("rst_load_err", {31'd0, load_err}, 32'd0);
    check("rst_ready", {29'd0, init_done, fetch_ready, load_ready}, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    wait_init();

    // Whole scrubbed array, back-to-back.
    for (int i = 0; i < 16; i++) fetch(32'(i * 4), 32'h0, 2'b00);

    // Load then fetch next cycle.
    load(32'h08, 32'hDEAD_BEEF, 1'b0);
    fetch(32'h08, 32'hDEAD_BEEF, 2'b00);

    // Load and fetch offered together: load wins, fetch refused then retried.
    load_valid = 1'b1; load_addr = 32'h10; load_data = 32'hCAFE_F00D;
    fetch_req = 1'b1; fetch_addr = 32'h10;
    #1;
    check("fetch_ready_blocked", {31'd0, fetch_ready}, 32'd0);
    @(posedge clk); #1;
    load_valid = 1'b0; fetch_req = 1'b0;
    check("load_err_both", {31'd0, load_err}, 32'd0);
    fetch(32'h10, 32'hCAFE_F00D, 2'b00);

    // Address errors.
    fetch(32'h06, NOP, 2'b01);
    fetch(32'h40, NOP, 2'b10);
    fetch(32'h42, NOP, 2'b01);
    fetch(32'h8000_0000, NOP, 2'b10);

    // Dropped loads leave the array unchanged (no aliasing of 0x40 onto word 0).
    load(32'h40, 32'h1234_5678, 1'b1);
    idle(1);
    check("load_err_pulse_end", {31'd0, load_err}, 32'd0);
    fetch(32'h00, 32'h0, 2'b00);
    load(32'h09, 32'h1111_2222, 1'b1);
    fetch(32'h08, 32'hDEAD_BEEF, 2'b00);

    // Last word, then outputs hold while idle.
    load(32'h3C, 32'hA5A5_0001, 1'b0);
    fetch(32'h3C, 32'hA5A5_0001, 2'b00);
    idle(2);
    check("hold_inst", fetch_inst, 32'hA5A5_0001);
    check("hold_err", {30'd0, fetch_err}, 32'd0);

    // Reset with a fetch result pending: the result is discarded.
    fetch_req = 1'b1; fetch_addr = 32'h08;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    nrst = 1'b0;
    #1;
    check("rst_clears_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_clears_inst", fetch_inst, NOP);
    @(posedge clk); #1;
    nrst = 1'b1;
    idle(7);
    // Reset again mid-scrub (counter at 7); the scrub restarts from word 0.
    nrst = 1'b0;
    #1;
    check("midscrub_init_done", {31'd0, init_done}, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    wait_init();
    fetch(32'h08, 32'h0, 2'b00);
    fetch(32'h3C, 32'h0, 2'b00);

`ifdef INST_MEM_PARITY_EN
    load(32'h08, 32'hDEAD_BEEF, 1'b0);
    fetch(32'h08, 32'hDEAD_BEEF, 2'b00);
    dut.mem_q[2][0] = ~dut.mem_q[2][0];
    fetch(32'h08, NOP, 2'b11);
    fetch(32'h06, NOP, 2'b01);
`endif

    idle(3);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
